// File: rtl/assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU replacement.
// Optional CACHE_STATS_EN adds saturating hit/miss counters (hit_count_o, miss_count_o).
module assoc_cache #(
  parameter int WAYS       = 4,
  parameter int SET_BITS   = 3,
  parameter int BLOCK_BITS = 2,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                                                   clk_i,
  input  logic                                                   reset_i,
  input  logic [ADDR_W-1:0]                                      address_i,
  input  logic                                                   c_read_i,
  input  logic                                                   c_wr_i,
  input  logic [WORD_W-1:0]                                      c_write_data_i,
  input  logic [WORD_W/8-1:0]                                    c_byte_en_i,
  output logic                                                   c_busywait_o,
  output logic [WORD_W-1:0]                                      c_data_o,
  output logic                                                   c_m_read_o,
  output logic                                                   c_m_wr_o,
  output logic [ADDR_W-BLOCK_BITS-$clog2(WORD_W/8)-1:0]          c_m_address_o,
  output logic [(WORD_W<<BLOCK_BITS)-1:0]                        c_m_write_data_o,
  input  logic                                                   c_m_busywait_i,
  input  logic [(WORD_W<<BLOCK_BITS)-1:0]                        c_m_read_data_i,
  input  logic                                                   m_read_done_i,
  input  logic                                                   m_write_done_i,
  output logic [1:0]                                             dbg_state_o
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                                            hit_count_o,
  output logic [31:0]                                            miss_count_o
`endif
);
  localparam int BYTE_BITS = $clog2(WORD_W/8);
  localparam int WAY_BITS  = $clog2(WAYS);
  localparam int SETS      = 1 << SET_BITS;
  localparam int TAG_W     = ADDR_W - BYTE_BITS - BLOCK_BITS - SET_BITS;
  localparam int BLK_W     = WORD_W << BLOCK_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE, S_REFILL} state_t;

  state_t r_state, w_next;

  logic                r_valid [WAYS][SETS];
  logic                r_dirty [WAYS][SETS];
  logic [WAY_BITS-1:0] r_age   [WAYS][SETS];
  logic [TAG_W-1:0]    r_tag   [WAYS][SETS];
  logic [BLK_W-1:0]    r_data  [WAYS][SETS];
  logic [WAY_BITS-1:0] r_victim;
  logic [BLK_W-1:0]    r_fill;

  logic [BLOCK_BITS-1:0] w_word;
  logic [SET_BITS-1:0]   w_index;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_req, w_hit, w_hit_idle, w_miss_idle, w_has_inv, w_lru_upd, w_unused;
  logic [WAY_BITS-1:0]   w_hit_way, w_inv_way, w_lru_way, w_victim, w_lru_sel;

  assign w_word   = address_i[BYTE_BITS +: BLOCK_BITS];
  assign w_index  = address_i[BYTE_BITS+BLOCK_BITS +: SET_BITS];
  assign w_tag    = address_i[ADDR_W-1 -: TAG_W];
  assign w_req    = c_read_i | c_wr_i;
  assign w_unused = ^{address_i[BYTE_BITS-1:0], c_m_busywait_i};

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    w_lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_index] && r_tag[w][w_index] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end
      if (r_age[w][w_index] == WAY_BITS'(WAYS-1)) w_lru_way = WAY_BITS'(w);
    end
    // Descending scan leaves the lowest-index invalid way selected.
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!r_valid[w][w_index]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_BITS'(w);
      end
    end
  end

  assign w_victim    = w_has_inv ? w_inv_way : w_lru_way;
  assign w_hit_idle  = (r_state == S_IDLE) && w_req && w_hit;
  assign w_miss_idle = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_lru_upd   = w_hit_idle || (r_state == S_REFILL);
  assign w_lru_sel   = (r_state == S_REFILL) ? r_victim : w_hit_way;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_miss_idle)
                     w_next = (r_valid[w_victim][w_index] && r_dirty[w_victim][w_index])
                              ? S_WRITEBACK : S_ALLOCATE;
      S_WRITEBACK: if (m_write_done_i) w_next = S_ALLOCATE;
      S_ALLOCATE:  if (m_read_done_i) w_next = S_REFILL;
      S_REFILL:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    c_busywait_o     = (r_state != S_IDLE) || w_miss_idle;
    c_data_o         = w_hit_idle ? r_data[w_hit_way][w_index][int'(w_word)*WORD_W +: WORD_W] : '0;
    c_m_wr_o         = (r_state == S_WRITEBACK);
    c_m_read_o       = (r_state == S_ALLOCATE);
    c_m_address_o    = '0;
    c_m_write_data_o = '0;
    if (r_state == S_WRITEBACK) begin
      c_m_address_o    = {r_tag[r_victim][w_index], w_index};
      c_m_write_data_o = r_data[r_victim][w_index];
    end else if (r_state == S_ALLOCATE) begin
      c_m_address_o    = {w_tag, w_index};
    end
  end

  assign dbg_state_o = r_state;

  // Line status and LRU ages; ages stay a permutation of 0..WAYS-1 per set.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_victim <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          r_valid[w][s] <= 1'b0;
          r_dirty[w][s] <= 1'b0;
          r_age[w][s]   <= WAY_BITS'(w);
        end
      end
    end else begin
      if (w_miss_idle) r_victim <= w_victim;
      if (w_lru_upd) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_BITS'(w) == w_lru_sel)
            r_age[w][w_index] <= '0;
          else if (r_age[w][w_index] < r_age[w_lru_sel][w_index])
            r_age[w][w_index] <= r_age[w][w_index] + 1'b1;
        end
      end
      if (r_state == S_REFILL) begin
        r_valid[r_victim][w_index] <= 1'b1;
        r_dirty[r_victim][w_index] <= 1'b0;
      end else if (w_hit_idle && c_wr_i) begin
        r_dirty[w_hit_way][w_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_state == S_ALLOCATE && m_read_done_i) r_fill <= c_m_read_data_i;
    if (r_state == S_REFILL) begin
      r_data[r_victim][w_index] <= r_fill;
      r_tag[r_victim][w_index]  <= w_tag;
    end else if (w_hit_idle && c_wr_i) begin
      for (int b = 0; b < WORD_W/8; b++)
        if (c_byte_en_i[b])
          r_data[w_hit_way][w_index][int'(w_word)*WORD_W + b*8 +: 8] <= c_write_data_i[b*8 +: 8];
    end
  end

`ifdef CACHE_STATS_EN
  logic        r_retry;
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // The first IDLE cycle after REFILL is the retry of the missed access, not a new hit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_retry    <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_retry <= (r_state == S_REFILL);
      if (w_hit_idle && !r_retry && r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 1'b1;
      if (w_miss_idle && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign hit_count_o  = r_hit_cnt;
  assign miss_count_o = r_miss_cnt;
`endif
endmodule
